// File: rtl/spi_reg_pkg.sv
// Shared types for the SPI register bank: receiver FSM states and frame width helper.
package spi_reg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_END
  } state_t;

  function automatic int frame_w(input int addr_w, input int data_w);
    return addr_w + data_w;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchroniser with registered rising/falling edge strobes.
module sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic sync_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta      <= RESET_VAL;
      sync      <= RESET_VAL;
      sync_prev <= RESET_VAL;
      rise      <= 1'b0;
      fall      <= 1'b0;
    end else begin
      meta      <= d;
      sync      <= meta;
      sync_prev <= sync;
      rise      <= sync & ~sync_prev;
      fall      <= ~sync & sync_prev;
    end
  end

  assign q = sync;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI-write register bank: frames land in shadow registers and are copied
// to the live image on an unlocked commit.
module spi_reg_bank
  import spi_reg_pkg::*;
#(
  parameter int NUM_REGS = 12,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALUE = '0
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_sclk,
  input  logic                       i_mosi,
  input  logic                       i_csb,
  input  logic                       i_commit,
  input  logic                       i_lock,
  output logic [NUM_REGS*DATA_W-1:0] o_regs,
  output logic [NUM_REGS-1:0]        o_pending,
  output logic                       o_frame_ok,
  output logic                       o_frame_err
);

  localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
  localparam int CNT_W   = $clog2(FRAME_W + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_W + 1);

  logic sclk_rise, sclk_level_unused, sclk_fall_unused;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;
  logic csb_level, csb_rise, csb_fall;

  sync_edge #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(i_clk), .rst_n(i_reset_n), .d(i_sclk),
    .q(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(i_clk), .rst_n(i_reset_n), .d(i_mosi),
    .q(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  sync_edge #(.RESET_VAL(1'b1)) u_sync_csb (
    .clk(i_clk), .rst_n(i_reset_n), .d(i_csb),
    .q(csb_level), .rise(csb_rise), .fall(csb_fall)
  );

  state_t                     state;
  logic [CNT_W-1:0]           bit_cnt;
  logic [FRAME_W-1:0]         shift_q;
  logic [NUM_REGS*DATA_W-1:0] live_q;
  logic [NUM_REGS*DATA_W-1:0] shadow_q;
  logic [NUM_REGS-1:0]        pending_q;
  logic                       frame_ok_q;
  logic                       frame_err_q;

  logic [ADDR_W-1:0] frame_addr;
  logic [DATA_W-1:0] frame_data;
  logic              frame_good;
  logic              wr_en;
  logic              do_commit;

  assign frame_addr = shift_q[FRAME_W-1 -: ADDR_W];
  assign frame_data = shift_q[DATA_W-1:0];
  assign frame_good = (bit_cnt == CNT_FULL) && (int'(frame_addr) < NUM_REGS);
  assign wr_en      = (state == ST_END) && frame_good;
  assign do_commit  = i_commit && !i_lock;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state       <= ST_IDLE;
      bit_cnt     <= '0;
      shift_q     <= '0;
      live_q      <= RESET_VALUE;
      shadow_q    <= RESET_VALUE;
      pending_q   <= '0;
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      frame_ok_q  <= 1'b0;
      frame_err_q <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (csb_fall) begin
            bit_cnt <= '0;
            shift_q <= '0;
            state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (csb_fall) begin
            bit_cnt <= '0;
            shift_q <= '0;
          end else if (sclk_rise && !csb_level) begin
            shift_q <= {shift_q[FRAME_W-2:0], mosi_level};
            if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + 1'b1;
          end
          if (csb_rise) state <= ST_END;
        end
        ST_END: begin
          frame_ok_q  <= frame_good;
          frame_err_q <= !frame_good;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      // A register written this cycle stays pending with its new data and skips the commit.
      for (int k = 0; k < NUM_REGS; k++) begin
        if (wr_en && (frame_addr == ADDR_W'(k))) begin
          shadow_q[k*DATA_W +: DATA_W] <= frame_data;
          pending_q[k]                 <= 1'b1;
        end else if (do_commit && pending_q[k]) begin
          live_q[k*DATA_W +: DATA_W] <= shadow_q[k*DATA_W +: DATA_W];
          pending_q[k]               <= 1'b0;
        end
      end
    end
  end

  assign o_regs      = live_q;
  assign o_pending   = pending_q;
  assign o_frame_ok  = frame_ok_q;
  assign o_frame_err = frame_err_q;

endmodule
